// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART TX scheduler: FSM state encoding and
// source identifiers used by the arbiter and the sequencing FSM.
package uart_tx_scheduler_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND    = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_SEND    = ST_SEND,
        S_WAIT_HI = ST_WAIT_HI,
        S_WAIT_LO = ST_WAIT_LO
    } sched_state_t;

    // Source index doubles as the bit position in the arbiter request/grant vectors.
    localparam int SRC_RF  = 0;
    localparam int SRC_ALU = 1;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle of the result-source handshakes and the transmitter byte/valid/busy
// signals around the scheduler.
interface uart_tx_scheduler_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      rf_rd_vld;
    logic [DATA_WIDTH-1:0]     rf_rd_data;
    logic                      alu_out_vld;
    logic [2*DATA_WIDTH-1:0]   alu_out;
    logic                      rf_ack;
    logic                      alu_ack;
    logic                      tx_busy;
    logic [DATA_WIDTH-1:0]     tx_p_data;
    logic                      tx_d_vld;
    logic                      sched_busy;
    logic                      tx_timeout_err;

    modport master (
        input  rf_rd_vld, rf_rd_data, alu_out_vld, alu_out, tx_busy,
        output rf_ack, alu_ack, tx_p_data, tx_d_vld, sched_busy, tx_timeout_err
    );

    modport slave (
        output rf_rd_vld, rf_rd_data, alu_out_vld, alu_out, tx_busy,
        input  rf_ack, alu_ack, tx_p_data, tx_d_vld, sched_busy, tx_timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the requester preferred
// on a tie and moves past whichever requester was granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);
    logic ptr;

    always_comb begin
        grant = req;
        if (req[0] && req[1]) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (en && (|req)) begin
            ptr <= grant[0];
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates RF (1-byte) and ALU (2-byte) results and feeds them one byte at a
// time to the UART transmitter, pacing on its busy flag with a request timeout.
//
// state   | meaning
// IDLE    | no result in flight, arbitrating
// SEND    | valid pulse to transmitter for the current byte
// WAIT_HI | waiting for transmitter busy to rise (timed)
// WAIT_LO | waiting for transmitter busy to fall
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_scheduler_if.master   bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    sched_state_t              state;
    logic [2*DATA_WIDTH-1:0]   byte_buf;
    logic [1:0]                byte_cnt;
    logic                      byte_idx;
    logic [CW-1:0]             to_cnt;
    logic [CW-1:0]             to_cnt_inc;
    logic [1:0]                req;
    logic [1:0]                grant;
    logic                      more_bytes;

    assign req        = {bus.alu_out_vld, bus.rf_rd_vld};
    assign to_cnt_inc = (to_cnt == CNT_MAX) ? to_cnt : to_cnt + CW'(1);
    assign more_bytes = (byte_cnt == 2'd2) && !byte_idx;

    // Byte stays selected from SEND through WAIT_LO since the transmitter samples late.
    assign bus.tx_p_data = byte_idx ? byte_buf[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : byte_buf[DATA_WIDTH-1:0];

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .en    (state == S_IDLE),
        .grant (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            byte_buf           <= '0;
            byte_cnt           <= 2'd0;
            byte_idx           <= 1'b0;
            to_cnt             <= '0;
            bus.rf_ack         <= 1'b0;
            bus.alu_ack        <= 1'b0;
            bus.tx_d_vld       <= 1'b0;
            bus.sched_busy     <= 1'b0;
            bus.tx_timeout_err <= 1'b0;
        end else begin
            bus.rf_ack         <= 1'b0;
            bus.alu_ack        <= 1'b0;
            bus.tx_d_vld       <= 1'b0;
            bus.tx_timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|grant) begin
                        if (grant[SRC_ALU]) begin
                            byte_buf <= bus.alu_out;
                            byte_cnt <= 2'd2;
                        end else begin
                            byte_buf <= {{DATA_WIDTH{1'b0}}, bus.rf_rd_data};
                            byte_cnt <= 2'd1;
                        end
                        byte_idx       <= 1'b0;
                        bus.rf_ack     <= grant[SRC_RF];
                        bus.alu_ack    <= grant[SRC_ALU];
                        bus.tx_d_vld   <= 1'b1;
                        bus.sched_busy <= 1'b1;
                        state          <= S_SEND;
                    end
                end
                S_SEND: begin
                    to_cnt <= '0;
                    state  <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (bus.tx_busy) begin
                        state <= S_WAIT_LO;
                    end else begin
                        to_cnt <= to_cnt_inc;
                        if (to_cnt_inc == CNT_MAX) begin
                            bus.tx_timeout_err <= 1'b1;
                            bus.sched_busy     <= 1'b0;
                            state              <= S_IDLE;
                        end
                    end
                end
                S_WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        if (more_bytes) begin
                            byte_idx     <= 1'b1;
                            bus.tx_d_vld <= 1'b1;
                            state        <= S_SEND;
                        end else begin
                            bus.sched_busy <= 1'b0;
                            state          <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Sequencing controller in front of the UART transmitter. It arbitrates between two result sources, the register-file read path (1 byte) and the ALU result path (2 bytes), and serialises each accepted result into single-byte transmit requests. It drives the transmitter's byte/valid inputs and paces itself on the transmitter's registered busy flag. It sits between the system controller datapath and the UART TX frame FSM, all in one clock domain.

## Interface
- DATA_WIDTH, 8: byte width presented to the transmitter
- TIMEOUT, 4: cycles allowed from a valid pulse to busy rising before the request is abandoned (≥3)

- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- RF_RD_VLD  in  1  register-file read result available; held until acked
- RF_RD_DATA  in  DATA_WIDTH  register-file read byte
- ALU_OUT_VLD  in  1  ALU result available; held until acked
- ALU_OUT  in  2*DATA_WIDTH  ALU result
- RF_ACK  out  1  one-cycle pulse: RF result captured
- ALU_ACK  out  1  one-cycle pulse: ALU result captured
- TX_BUSY  in  1  registered busy from the UART TX FSM
- TX_P_DATA  out  DATA_WIDTH  byte to the transmitter
- TX_D_VLD  out  1  one-cycle transmit request
- SCHED_BUSY  out  1  high whenever the state is not IDLE
- TX_TIMEOUT_ERR  out  1  one-cycle pulse on abandoned request

## Operation
- Reset values: all outputs 0. State IDLE, round-robin pointer = RF-preferred, byte buffer 0, byte index 0, timeout counter 0.
- States: IDLE, SEND, WAIT_HI, WAIT_LO.
- IDLE: if either valid is high, grant one source, capture its data into a 2-byte buffer, set byte count (RF=1, ALU=2), go to SEND. Otherwise stay in IDLE.
- Arbitration: when only one source is valid, grant it. When both are valid, grant the source the pointer prefers, then point the pointer at the other source. The pointer updates only on a grant.
- ACK: pulse in the first SEND cycle of a grant only, never for the second ALU byte.
- SEND: TX_D_VLD=1 for exactly one cycle and TX_P_DATA = current byte. Clear the counter and go to WAIT_HI.
- ALU byte order: ALU_OUT[7:0] first, then ALU_OUT[15:8].
- WAIT_HI: wait for TX_BUSY=1, then go to WAIT_LO. The counter increments each cycle. If the counter reaches TIMEOUT with no busy, pulse TX_TIMEOUT_ERR, discard the remaining bytes and return to IDLE.
- WAIT_LO: wait for TX_BUSY=0. Then, if bytes remain, advance the index and go to SEND; otherwise go to IDLE. There is no timeout in WAIT_LO.
- TX_P_DATA holds the current byte from SEND through WAIT_LO, because the transmitter samples it after the valid pulse.
- Reset mid-operation: immediate return to reset values. A partially sent ALU result is dropped and is not re-requested.

## Timing
- A valid sampled high in IDLE at edge t gives: ACK and TX_D_VLD high in cycle t+1, state WAIT_HI at t+2.
- The transmitter's busy flag rises 2 cycles after its valid. The nominal WAIT_HI dwell is therefore 1–2 cycles.
- The second ALU byte's TX_D_VLD is asserted the cycle after busy is observed low.
- Minimum gap between results: back-to-back requests see IDLE → SEND with one IDLE cycle between groups.
- A source dropping valid before ACK is legal. It is simply not granted.
- Both sources valid in the same cycle that the pointer flips: the pointer value in use is the one registered before the edge.

## Structure
- The shared package holds:
  - state encoding localparams (2-bit: IDLE=0, SEND=1, WAIT_HI=2, WAIT_LO=3)
  - source-select constants (SRC_RF=0, SRC_ALU=1)
- One natural sub-module: `rr_arb2`, a two-requester round-robin arbiter with a registered pointer and a grant-enable input.
- Timeout counter: $clog2(TIMEOUT+1) bits, saturating.

## Test plan
- Single RF read, RF_RD_DATA=0xA5; model busy rising 2 cycles after valid and falling 100 cycles later. Required: one TX_D_VLD with 0xA5, RF_ACK at the same cycle, SCHED_BUSY low after busy falls.
- ALU_OUT=0x1234. Required: TX_D_VLD with 0x34, then, after busy falls, a second pulse with 0x12. ALU_ACK pulses once.
- Both valid every cycle for 4 results. Required: grant order RF, ALU, RF, ALU and byte stream 0xRF, lo, hi, 0xRF, lo, hi.
- TX_BUSY stuck 0 after valid, TIMEOUT=4. Required: TX_TIMEOUT_ERR pulses once, 4 cycles after entering WAIT_HI, and the state returns to IDLE. For an ALU request the second byte is never sent.
- RST asserted during WAIT_LO of the ALU low byte. Required: all outputs 0 immediately, no high-byte request after release, RF-preferred grant on the next simultaneous request.
